// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin arbiter that lets two requesters share one I2C
// master. The winning requester owns the master until its final byte is
// acknowledged or an ack timeout fires, after which the bus is held idle
// for GAP_CYCLES cycles before the next grant.
//
// Ports
//   i_sysclk          clock (rising edge)
//   i_arst            synchronous active-high reset
//   i_reqN            requester N wants the master (level)
//   i_wrN             requester N direction
//   i_dataN [7:0]     requester N current byte
//   i_lastN           requester N current byte is the final one
//   o_gntN            requester N owns the master (registered, one-hot/zero)
//   o_ackN            current byte of requester N consumed (combinational)
//   o_doneN           one-cycle pulse: transaction finished normally
//   o_errN            one-cycle pulse: transaction aborted by timeout
//   o_m_en            master enable (registered)
//   o_m_wr            granted direction, 0 when idle (combinational)
//   o_m_last          one-cycle end-of-transaction strobe (registered)
//   o_m_data [7:0]    granted byte, 0x00 when idle (combinational)
//   i_m_ack           master consumed the current byte (pulse)
module i2c_arbiter #(
  parameter int unsigned GAP_CYCLES     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic       i_sysclk,
  input  logic       i_arst,
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic       i_wr0,
  input  logic       i_wr1,
  input  logic [7:0] i_data0,
  input  logic [7:0] i_data1,
  input  logic       i_last0,
  input  logic       i_last1,
  output logic       o_gnt0,
  output logic       o_gnt1,
  output logic       o_ack0,
  output logic       o_ack1,
  output logic       o_done0,
  output logic       o_done1,
  output logic       o_err0,
  output logic       o_err1,
  output logic       o_m_en,
  output logic       o_m_wr,
  output logic       o_m_last,
  output logic [7:0] o_m_data,
  input  logic       i_m_ack
);

  localparam int unsigned DataW = 8;
  localparam int unsigned ToW   = 16;
  localparam int unsigned GapW  = 8;

  localparam logic [ToW-1:0]  ToTerm  = ToW'(TIMEOUT_CYCLES);
  localparam logic [GapW-1:0] GapTerm = GapW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [1:0]      done_q, done_d;
  logic [1:0]      err_q, err_d;
  logic            m_en_q, m_en_d;
  logic            m_last_q, m_last_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic            to_phase_q, to_phase_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
  // Port that received the most recent grant; reset to 1 so port 0 wins the first tie.
  logic            last_port_q, last_port_d;

  logic            pick1;
  logic            sel_last;

  // Tie goes to the port not served last; a lone requester always wins.
  assign pick1    = i_req1 & (~i_req0 | ~last_port_q);
  assign sel_last = gnt_q[1] ? i_last1 : i_last0;

  // State and output registers.
  always_ff @(posedge i_sysclk) begin
    if (i_arst) begin
      state_q     <= S_IDLE;
      gnt_q       <= 2'b00;
      done_q      <= 2'b00;
      err_q       <= 2'b00;
      m_en_q      <= 1'b0;
      m_last_q    <= 1'b0;
      to_cnt_q    <= '0;
      to_phase_q  <= 1'b0;
      gap_cnt_q   <= '0;
      last_port_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      m_en_q      <= m_en_d;
      m_last_q    <= m_last_d;
      to_cnt_q    <= to_cnt_d;
      to_phase_q  <= to_phase_d;
      gap_cnt_q   <= gap_cnt_d;
      last_port_q <= last_port_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    done_d      = 2'b00;
    err_d       = 2'b00;
    m_en_d      = m_en_q;
    m_last_d    = 1'b0;
    to_cnt_d    = to_cnt_q;
    to_phase_d  = to_phase_q;
    gap_cnt_d   = gap_cnt_q;
    last_port_d = last_port_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_req0 | i_req1) begin
          state_d     = S_XFER;
          gnt_d       = pick1 ? 2'b10 : 2'b01;
          last_port_d = pick1;
          m_en_d      = 1'b1;
          to_cnt_d    = '0;
          to_phase_d  = 1'b0;
        end
      end

      S_XFER: begin
        // An ack wins over a coincident terminal count.
        if (i_m_ack) begin
          to_cnt_d   = '0;
          to_phase_d = 1'b0;
          if (sel_last) begin
            state_d   = S_GAP;
            gnt_d     = 2'b00;
            m_en_d    = 1'b0;
            m_last_d  = 1'b1;
            done_d    = gnt_q;
            gap_cnt_d = '0;
          end
        end else if (to_cnt_q == ToTerm) begin
          state_d   = S_GAP;
          gnt_d     = 2'b00;
          m_en_d    = 1'b0;
          m_last_d  = 1'b1;
          err_d     = gnt_q;
          gap_cnt_d = '0;
        end else begin
          // Counter advances on every second ack-free cycle.
          to_phase_d = ~to_phase_q;
          if (to_phase_q) begin
            to_cnt_d = to_cnt_q + ToW'(1);
          end
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GapTerm) begin
          state_d   = S_IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_gnt0   = gnt_q[0];
  assign o_gnt1   = gnt_q[1];
  assign o_done0  = done_q[0];
  assign o_done1  = done_q[1];
  assign o_err0   = err_q[0];
  assign o_err1   = err_q[1];
  assign o_m_en   = m_en_q;
  assign o_m_last = m_last_q;

  // Grant is only ever set while transferring, so gating by it also
  // suppresses acks outside the transfer phase.
  assign o_ack0   = i_m_ack & gnt_q[0];
  assign o_ack1   = i_m_ack & gnt_q[1];

  assign o_m_data = gnt_q[0] ? i_data0 :
                    gnt_q[1] ? i_data1 : DataW'(0);
  assign o_m_wr   = (gnt_q[0] & i_wr0) | (gnt_q[1] & i_wr1);

endmodule

// File: tb/tb_i2c_arbiter.sv
// Testbench for i2c_arbiter: directed scenarios followed by randomized
// traffic, every cycle compared against a transaction-level reference model.
module tb_i2c_arbiter;

  localparam int GAP = 4;
  localparam int TO  = 16;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic       wr0 = 1'b0, wr1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       last0 = 1'b0, last1 = 1'b0;
  logic       m_ack = 1'b0;

  logic       gnt0, gnt1, ack0, ack1, done0, done1, err0, err1;
  logic       m_en, m_wr, m_last;
  logic [7:0] m_data;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: owner (-1 none), ack-free cycles in the current
  // transfer, remaining gap cycles, and which port wins the next tie.
  int         own = -1;
  int         quiet = 0;
  int         gap_left = 0;
  int         prefer = 0;
  bit         e_mlast = 1'b0;
  bit [1:0]   e_done = 2'b00;
  bit [1:0]   e_err = 2'b00;

  i2c_arbiter #(
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_sysclk (clk),
    .i_arst   (arst),
    .i_req0   (req0),
    .i_req1   (req1),
    .i_wr0    (wr0),
    .i_wr1    (wr1),
    .i_data0  (data0),
    .i_data1  (data1),
    .i_last0  (last0),
    .i_last1  (last1),
    .o_gnt0   (gnt0),
    .o_gnt1   (gnt1),
    .o_ack0   (ack0),
    .o_ack1   (ack1),
    .o_done0  (done0),
    .o_done1  (done1),
    .o_err0   (err0),
    .o_err1   (err1),
    .o_m_en   (m_en),
    .o_m_wr   (m_wr),
    .o_m_last (m_last),
    .o_m_data (m_data),
    .i_m_ack  (m_ack)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Advance the model across one rising edge using the inputs held during the cycle.
  function automatic void model_step();
    bit cur_last;
    e_mlast = 1'b0;
    e_done  = 2'b00;
    e_err   = 2'b00;
    if (arst) begin
      own = -1; quiet = 0; gap_left = 0; prefer = 0;
      return;
    end
    if (own >= 0) begin
      cur_last = (own == 0) ? last0 : last1;
      if (m_ack && cur_last) begin
        e_done[own] = 1'b1;
        e_mlast = 1'b1; gap_left = GAP; own = -1;
      end else if (m_ack) begin
        quiet = 0;
      end else if (quiet == 2 * TO) begin
        e_err[own] = 1'b1;
        e_mlast = 1'b1; gap_left = GAP; own = -1;
      end else begin
        quiet++;
      end
    end else if (gap_left > 0) begin
      gap_left--;
    end else if (req0 || req1) begin
      own    = (req0 && req1) ? prefer : (req0 ? 0 : 1);
      prefer = 1 - own;
      quiet  = 0;
    end
  endfunction

  task automatic check_outputs();
    logic [7:0] exp_data;
    logic       exp_wr;
    exp_data = (own == 0) ? data0 : (own == 1) ? data1 : 8'h00;
    exp_wr   = (own == 0) ? wr0 : (own == 1) ? wr1 : 1'b0;
    check_eq("gnt0",   gnt0,   8'(own == 0));
    check_eq("gnt1",   gnt1,   8'(own == 1));
    check_eq("m_en",   m_en,   8'(own >= 0));
    check_eq("ack0",   ack0,   8'(m_ack && own == 0));
    check_eq("ack1",   ack1,   8'(m_ack && own == 1));
    check_eq("done0",  done0,  8'(e_done[0]));
    check_eq("done1",  done1,  8'(e_done[1]));
    check_eq("err0",   err0,   8'(e_err[0]));
    check_eq("err1",   err1,   8'(e_err[1]));
    check_eq("m_last", m_last, 8'(e_mlast));
    check_eq("m_data", m_data, exp_data);
    check_eq("m_wr",   m_wr,   8'(exp_wr));
  endtask

  // One cycle: inputs were set at the preceding falling edge.
  task automatic cyc();
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic quiet_inputs();
    req0 = 1'b0; req1 = 1'b0; m_ack = 1'b0; last0 = 1'b0; last1 = 1'b0;
  endtask

  initial begin
    logic [7:0] bytes [3];
    int ack_pct;
    bytes[0] = 8'h78; bytes[1] = 8'h30; bytes[2] = 8'h08;

    repeat (2) @(posedge clk);
    model_step();
    @(negedge clk);
    cyc();
    arst = 1'b0;

    // Single-port three-byte write.
    wr0 = 1'b1; req0 = 1'b1; data0 = bytes[0];
    cyc();
    for (int i = 0; i < 3; i++) begin
      data0 = bytes[i]; last0 = (i == 2); m_ack = 1'b1;
      cyc();
    end
    quiet_inputs();
    repeat (7) cyc();

    // Tie after reset, back-to-back one-byte transfers; acks during gaps ignored.
    arst = 1'b1; cyc(); arst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; last0 = 1'b1; last1 = 1'b1; m_ack = 1'b1;
    data0 = 8'hA5; data1 = 8'h5A; wr1 = 1'b0;
    repeat (20) cyc();
    quiet_inputs();
    repeat (6) cyc();

    // Timeout with no acks at all.
    arst = 1'b1; cyc(); arst = 1'b0;
    req0 = 1'b1;
    repeat (2 * TO + 4) cyc();
    req0 = 1'b0;
    repeat (6) cyc();

    // Final ack coinciding with the terminal count.
    arst = 1'b1; cyc(); arst = 1'b0;
    req0 = 1'b1; cyc();
    req0 = 1'b0;
    repeat (2 * TO) cyc();
    m_ack = 1'b1; last0 = 1'b1; cyc();
    quiet_inputs();
    repeat (6) cyc();

    // Non-final ack on the terminal count, then timeout later.
    req1 = 1'b1; cyc();
    repeat (2 * TO) cyc();
    m_ack = 1'b1; cyc();
    m_ack = 1'b0; req1 = 1'b0;
    repeat (2 * TO + 8) cyc();

    // Reset in the middle of a transfer, then a port-1-only request.
    req0 = 1'b1; cyc(); cyc();
    arst = 1'b1; req0 = 1'b0; req1 = 1'b1; cyc();
    arst = 1'b0; cyc(); cyc();
    quiet_inputs();
    arst = 1'b1; cyc(); arst = 1'b0;

    // Requester drops its request after the first of two acks.
    req1 = 1'b1; data1 = 8'h11; cyc();
    m_ack = 1'b1; cyc();
    m_ack = 1'b0; req1 = 1'b0; data1 = 8'h22; repeat (3) cyc();
    m_ack = 1'b1; last1 = 1'b1; cyc();
    quiet_inputs();
    repeat (6) cyc();

    // Randomized traffic with varying ack density.
    for (int ph = 0; ph < 9; ph++) begin
      case (ph % 3)
        0:       ack_pct = 50;
        1:       ack_pct = 12;
        default: ack_pct = 0;
      endcase
      for (int c = 0; c < 250; c++) begin
        arst  = ($urandom_range(0, 299) == 0);
        if ($urandom_range(0, 9) == 0) req0 = ~req0;
        if ($urandom_range(0, 9) == 0) req1 = ~req1;
        wr0   = 1'($urandom_range(0, 1));
        wr1   = 1'($urandom_range(0, 1));
        data0 = 8'($urandom_range(0, 255));
        data1 = 8'($urandom_range(0, 255));
        last0 = ($urandom_range(0, 2) == 0);
        last1 = ($urandom_range(0, 2) == 0);
        m_ack = ($urandom_range(0, 99) < ack_pct);
        cyc();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
